// File: rtl/slice_pkg.sv
// Shared types and width helpers for the field packing/unpacking path.
package slice_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // MSB index of a packed word that starts at word_lo.
  function automatic int word_msb(input int word_lo, input int field_w, input int num_fields);
    return word_lo + field_w * num_fields - 1;
  endfunction

  // Width of a field count that must be able to hold num_fields itself.
  function automatic int count_w(input int num_fields);
    return $clog2(num_fields + 1);
  endfunction

  function automatic int index_w(input int num_fields);
    return (num_fields > 1) ? $clog2(num_fields) : 1;
  endfunction

endpackage

// File: rtl/slice_field_extend.sv
// Combinational FIELD_W -> OUT_W sign/zero extender driving an offset-range output.
module slice_field_extend #(
  parameter int FIELD_W    = 7,
  parameter int OUT_W      = 17,
  parameter int OUT_LO     = 5,
  parameter int SIGNED_EXT = 1
) (
  input  logic [FIELD_W-1:0]             field_in,
  output logic [OUT_LO+OUT_W-1:OUT_LO]   field_out
);

  logic [OUT_W-1:0] ext;
  logic             fill;

  assign fill = (SIGNED_EXT != 0) && field_in[FIELD_W-1];

  // Built bit by bit so OUT_W == FIELD_W needs no special case.
  always_comb begin
    ext = '0;
    ext[FIELD_W-1:0] = field_in;
    for (int i = FIELD_W; i < OUT_W; i++) begin
      ext[i] = fill;
    end
  end

  assign field_out = ext;

endmodule

// File: rtl/slice_field_unpacker.sv
// Unpacks a packed word of NUM_FIELDS fields and emits them lowest first, extended.
module slice_field_unpacker
  import slice_pkg::*;
#(
  parameter int FIELD_W       = 7,
  parameter int NUM_FIELDS    = 4,
  parameter int WORD_LO       = 8,
  parameter int OUT_LO        = 5,
  parameter int OUT_W         = 17,
  parameter int SIGNED_FIELDS = 1
) (
  input  logic                                             clock_0,
  input  logic                                             reset_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [word_msb(WORD_LO,FIELD_W,NUM_FIELDS):WORD_LO] in_word,
  input  logic [count_w(NUM_FIELDS)-1:0]                   in_count,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [OUT_LO+OUT_W-1:OUT_LO]                     out_field,
  output logic                                             out_last,
  output logic [index_w(NUM_FIELDS)-1:0]                   out_index
);

  localparam int WORD_W = FIELD_W * NUM_FIELDS;
  localparam int CNT_W  = count_w(NUM_FIELDS);
  localparam int IDX_W  = index_w(NUM_FIELDS);
  localparam logic [CNT_W-1:0] NF_CNT = CNT_W'(NUM_FIELDS);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [WORD_W-1:0]  word_in;
  logic [CNT_W-1:0]   eff_count;
  logic               accept;
  logic               take;

  assign word_in = in_word;

  always_comb begin
    eff_count = in_count;
    if ((in_count == '0) || (in_count > NF_CNT)) begin
      eff_count = NF_CNT;
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid and data stable until that edge; in_ready also
  // opens in the cycle the last field is taken so words stream without a bubble.
  assign out_valid = (state_q == EMIT);
  assign out_last  = (remaining_q == CNT_W'(1));
  assign take      = out_valid && out_ready;
  assign in_ready  = (state_q == IDLE) || (take && out_last);
  assign accept    = in_valid && in_ready;
  assign out_index = index_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    if (accept) begin
      state_d     = EMIT;
      shift_d     = word_in;
      remaining_d = eff_count;
      index_d     = '0;
    end else if (take) begin
      if (out_last) begin
        state_d     = IDLE;
        shift_d     = '0;
        remaining_d = '0;
        index_d     = '0;
      end else begin
        shift_d     = shift_q >> FIELD_W;
        remaining_d = remaining_q - CNT_W'(1);
        index_d     = index_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock_0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      remaining_q <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
    end
  end

  slice_field_extend #(
    .FIELD_W   (FIELD_W),
    .OUT_W     (OUT_W),
    .OUT_LO    (OUT_LO),
    .SIGNED_EXT(SIGNED_FIELDS)
  ) u_extend (
    .field_in (shift_q[FIELD_W-1:0]),
    .field_out(out_field)
  );

endmodule

// File: tb/tb_slice_field_unpacker.sv
// Scoreboard bench for slice_field_unpacker: signed and unsigned instances share stimulus.
module tb_slice_field_unpacker;

  localparam int EW = 20;  // {last, index[1:0], field[16:0]}

  logic        clock_0 = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [27:0] in_word;
  logic [2:0]  in_count;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, out_last_s;
  logic [16:0] out_field_s;
  logic [1:0]  out_index_s;
  logic        in_ready_u, out_valid_u, out_last_u;
  logic [16:0] out_field_u;
  logic [1:0]  out_index_u;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_u_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock_0 = ~clock_0;

  slice_field_unpacker #(.SIGNED_FIELDS(1)) dut_s (
    .clock_0(clock_0), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_word(in_word), .in_count(in_count),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_field(out_field_s),
    .out_last(out_last_s), .out_index(out_index_s)
  );

  slice_field_unpacker #(.SIGNED_FIELDS(0)) dut_u (
    .clock_0(clock_0), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_word(in_word), .in_count(in_count),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_field(out_field_u),
    .out_last(out_last_u), .out_index(out_index_u)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [16:0] fs, input logic [16:0] fu,
                      input logic [1:0] idx, input logic last);
    exp_q.push_back({last, idx, fs});
    exp_u_q.push_back({last, idx, fu});
  endtask

  // Expectations for 28'h2B03F83: fields 03, 7F, 40, 15.
  task automatic push_main(input int n);
    logic [16:0] fs[4];
    logic [16:0] fu[4];
    fs[0] = 17'h00003; fs[1] = 17'h1FFFF; fs[2] = 17'h1FFC0; fs[3] = 17'h00015;
    fu[0] = 17'h00003; fu[1] = 17'h0007F; fu[2] = 17'h00040; fu[3] = 17'h00015;
    for (int i = 0; i < n; i++) push(fs[i], fu[i], 2'(i), (i == n - 1));
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input logic [27:0] w, input logic [2:0] c);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    in_valid = 1'b1;
    in_word  = w;
    in_count = c;
    while (!got && n < 200) begin
      @(negedge clock_0);
      if (in_ready_s) begin
        got = 1;
        if (out_valid_s) check("ready_only_on_last", {31'b0, out_last_s}, 32'd1);
      end
      @(posedge clock_0);
      #1;
      n++;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_word  = 28'($urandom);
    in_count = 3'($urandom_range(0, 7));
    check("accept_latency_valid", {31'b0, out_valid_s}, 32'd1);
    check("accept_index", {30'b0, out_index_s}, 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_u_q.size() != 0) && n < 200) begin
      @(posedge clock_0);
      n++;
    end
    #1;
    check("drain", {31'b0, (n >= 200)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_count  = '0;
    out_ready = 1'b1;

    fork
      forever begin
        logic [EW-1:0] e;
        @(negedge clock_0);
        if (reset_n && out_valid_s && out_ready) begin
          if (exp_q.size() == 0) check("sb_signed_unexpected", {12'b0, out_last_s, out_index_s, out_field_s}, 32'hFFFFFFFF);
          else begin
            e = exp_q.pop_front();
            check("sb_signed", {12'b0, out_last_s, out_index_s, out_field_s}, {12'b0, e});
          end
        end
        if (reset_n && out_valid_u && out_ready) begin
          if (exp_u_q.size() == 0) check("sb_unsigned_unexpected", {12'b0, out_last_u, out_index_u, out_field_u}, 32'hFFFFFFFF);
          else begin
            e = exp_u_q.pop_front();
            check("sb_unsigned", {12'b0, out_last_u, out_index_u, out_field_u}, {12'b0, e});
          end
        end
      end
    join_none

    #2;
    check("rst_valid", {31'b0, out_valid_s}, 32'd0);
    check("rst_field", {15'b0, out_field_s}, 32'd0);
    check("rst_last",  {31'b0, out_last_s}, 32'd0);
    check("rst_index", {30'b0, out_index_s}, 32'd0);
    repeat (2) @(posedge clock_0);
    #1 reset_n = 1'b1;
    @(negedge clock_0);
    check("rst_in_ready", {31'b0, in_ready_s}, 32'd1);
    @(posedge clock_0);
    #1;

    // Basic unpack of all four fields.
    push_main(4);
    send_word(28'h2B03F83, 3'd4);
    wait_drain();

    // Backpressure on field 1 for three cycles.
    push_main(4);
    send_word(28'h2B03F83, 3'd4);
    @(posedge clock_0);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_0);
      check("bp_valid", {31'b0, out_valid_s}, 32'd1);
      check("bp_field", {15'b0, out_field_s}, 32'h1FFFF);
      check("bp_field_u", {15'b0, out_field_u}, 32'h0007F);
      check("bp_index", {30'b0, out_index_s}, 32'd1);
      check("bp_last", {31'b0, out_last_s}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready_s}, 32'd0);
    end
    @(posedge clock_0);
    #1 out_ready = 1'b1;
    wait_drain();

    // Back-to-back words: second loads as the last field of the first is taken.
    push_main(4);
    push(17'h00001, 17'h00001, 2'd0, 1'b1);
    send_word(28'h2B03F83, 3'd4);
    send_word(28'h0000001, 3'd1);
    wait_drain();

    // Short and out-of-range counts.
    push_main(1);
    send_word(28'h2B03F83, 3'd1);
    push_main(4);
    send_word(28'h2B03F83, 3'd0);
    push_main(4);
    send_word(28'h2B03F83, 3'd6);
    push(17'h1FFC0, 17'h00040, 2'd0, 1'b0);
    push(17'h0003F, 17'h0003F, 2'd1, 1'b0);
    push(17'h00001, 17'h00001, 2'd2, 1'b1);
    send_word(28'hFE05FC0, 3'd3);
    wait_drain();
    @(negedge clock_0);
    check("idle_valid", {31'b0, out_valid_s}, 32'd0);
    check("idle_in_ready", {31'b0, in_ready_s}, 32'd1);
    @(posedge clock_0);
    #1;

    // Asynchronous reset after field 1 has been taken.
    push_main(4);
    send_word(28'h2B03F83, 3'd4);
    @(posedge clock_0);
    #1;
    @(posedge clock_0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid_s}, 32'd0);
    check("mid_rst_field", {15'b0, out_field_s}, 32'd0);
    check("mid_rst_index", {30'b0, out_index_s}, 32'd0);
    check("mid_rst_last",  {31'b0, out_last_s}, 32'd0);
    exp_q.delete();
    exp_u_q.delete();
    repeat (2) @(posedge clock_0);
    #1 reset_n = 1'b1;
    @(negedge clock_0);
    check("post_rst_in_ready", {31'b0, in_ready_s}, 32'd1);
    check("post_rst_valid", {31'b0, out_valid_s}, 32'd0);
    @(posedge clock_0);
    #1;
    push_main(4);
    send_word(28'h2B03F83, 3'd4);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
